dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory DMEM (256 x 32, combinational read, write on posedge CLK).
- Port A is the CPU load/store unit. Port B is the loader/debug master.
- Serialises requests, drives the DMEM control/address/data lines from registers, and returns read data with a valid pulse.
- Round-robin between ports; out-of-range addresses are blocked.

Parameters:
- DEPTH, 256, number of 32-bit words in DMEM; addresses >= DEPTH are out of range.
- DATA_W, 32, data width.
- ADDR_W, 32, address width (word address, as DMEM uses it).

Ports:
- CLK  input  1  system clock, all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- a_req  input  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt.
- a_we  input  1  1 = write, 0 = read.
- a_addr  input  ADDR_W  word address.
- a_wdata  input  DATA_W  write data.
- a_gnt  output  1  one-cycle pulse: command accepted.
- a_rvalid  output  1  one-cycle pulse: access completed (read data valid or write done).
- a_rdata  output  DATA_W  read data, held until next port A read completes.
- a_err  output  1  pulses with a_rvalid when the address was out of range.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_err: same as port A, for port B.
- DMEM_address  output  ADDR_W  to DMEM.
- DMEM_data_in  output  DATA_W  to DMEM.
- DMEM_mem_write  output  1  to DMEM.
- DMEM_mem_read  output  1  to DMEM.
- DMEM_data_out  input  DATA_W  from DMEM.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, last=B. All outputs 0: gnt, rvalid, err, rdata, DMEM_* outputs.
- Reset mid-ACCESS aborts the access. No DMEM write occurs at any edge while RST_N is low. No rvalid is produced.
- FSM states: IDLE, ACCESS.
- IDLE, at each edge:
  - Requests are sampled only in IDLE.
  - If any req is high, pick the winner: the single requester, or on a tie the port != last.
  - Latch the winner's we/addr/wdata; set its gnt=1 and last=winner; go to ACCESS.
  - If no req, stay in IDLE with all pulses 0.
- ACCESS (exactly one cycle):
  - DMEM_address = latched address.
  - In range: DMEM_mem_write = we, DMEM_mem_read = !we.
  - Out of range: both strobes 0 and DMEM_address = 0.
  - At the closing edge: DMEM commits a write. For a read, rdata_x <= DMEM_data_out; for an out-of-range read, rdata_x <= 0.
  - rvalid_x=1, err_x = out-of-range; gnt cleared; go to IDLE.
- Outside ACCESS, DMEM strobes are 0 and DMEM_address/DMEM_data_in hold their last values.
- Latency: req sampled at edge E0 -> gnt high in cycle E0..E1 -> rvalid/rdata at E1..E2. Throughput is 1 access per 2 cycles.
- The requester updates req after seeing gnt. A req still high when next sampled (E2) is a new request.
- Back-to-back with both ports requesting continuously: strict alternation A, B, A, B...
- Writes never update rdata_x.
- gnt_a and gnt_b are never high together, and neither are the DMEM strobes.

Optional Feature:
- DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs a_cnt[15:0], b_cnt[15:0] (grants per port) and conflict_cnt[15:0] (IDLE edges with both req high).
  - All three are saturating at 16'hFFFF and reset to 0.
  - Adds input stats_clr: a synchronous clear of the counters, which takes priority over increments.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold RST_N=0 with a_req=1, a_we=1 -> no gnt, DMEM_mem_write=0, all outputs 0; release -> first grant to A.
- Single write then read, port A: write 32'hDEADBEEF @ addr 5 -> a_gnt 1 cycle after req, a_rvalid next cycle; read @5 -> a_rdata=32'hDEADBEEF with a_rvalid, a_err=0.
- Contention: a_req and b_req high together from reset -> grants A, B, A, B on consecutive IDLE edges; never both gnt high together.
- Out of range: b_req read @ addr 256 -> DMEM_mem_read=0 during ACCESS; b_rvalid=1, b_err=1, b_rdata=0. A write @300 leaves mem[0..255] unchanged.
- Mid-access reset: pull RST_N low during ACCESS of a write of 32'h12345678 @7 -> a later read @7 returns the prior value; no a_rvalid.
- STATS_EN: 3 contention rounds -> conflict_cnt increments once per contended IDLE edge; a_cnt/b_cnt = grants per port; stats_clr -> all 0 next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer in front of a
// single-port 256x32 data memory (combinational read, write on posedge CLK).
// Port A = CPU load/store unit, port B = loader/debug master.
// Handshake: a requester raises x_req with x_we/x_addr/x_wdata stable and
//   holds them until x_gnt pulses (command accepted in IDLE). Exactly one
//   cycle later x_rvalid pulses (with x_err if the address was out of range);
//   x_rdata holds the last completed read of that port. A req still high at
//   the next IDLE sample is treated as a new request.
// Optional feature macro: DMEM_ARB_STATS_EN adds grant/conflict counters
//   (a_cnt, b_cnt, conflict_cnt) and a synchronous stats_clr input.
module dmem_arbiter #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] DMEM_address,
  output logic [DATA_W-1:0] DMEM_data_in,
  output logic              DMEM_mem_write,
  output logic              DMEM_mem_read,
  input  logic [DATA_W-1:0] DMEM_data_out,
`ifdef DMEM_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       a_cnt,
  output logic [15:0]       b_cnt,
  output logic [15:0]       conflict_cnt,
`endif
  output logic              dbg_state
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

  state_t            state, state_nxt;
  logic              last_b;   // 1 = port B won the most recent grant
  logic              cur_b;    // port owning the access in flight
  logic              we_q;
  logic              oor_q;    // access in flight is out of range
  logic              grant_en;
  logic              win_b;
  logic              sel_we;
  logic              sel_in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign dbg_state = state;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and winner selection; a tie goes to the port that did not win last
  always_comb begin
    state_nxt    = state;
    grant_en     = 1'b0;
    win_b        = 1'b0;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant_en  = 1'b1;
          win_b     = b_req && (!a_req || !last_b);
          state_nxt = ACCESS;
        end
      end
      ACCESS: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    sel_we       = win_b ? b_we    : a_we;
    sel_addr     = win_b ? b_addr  : a_addr;
    sel_wdata    = win_b ? b_wdata : a_wdata;
    sel_in_range = sel_addr < DEPTH_L;
  end

  // Command latch, DMEM drive registers, grant/completion pulses and read data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_b         <= 1'b1;
      cur_b          <= 1'b0;
      we_q           <= 1'b0;
      oor_q          <= 1'b0;
      a_gnt          <= 1'b0;
      b_gnt          <= 1'b0;
      a_rvalid       <= 1'b0;
      b_rvalid       <= 1'b0;
      a_err          <= 1'b0;
      b_err          <= 1'b0;
      a_rdata        <= '0;
      b_rdata        <= '0;
      DMEM_address   <= '0;
      DMEM_data_in   <= '0;
      DMEM_mem_write <= 1'b0;
      DMEM_mem_read  <= 1'b0;
    end else begin
      a_gnt    <= grant_en && !win_b;
      b_gnt    <= grant_en && win_b;
      a_rvalid <= (state == ACCESS) && !cur_b;
      b_rvalid <= (state == ACCESS) && cur_b;
      a_err    <= (state == ACCESS) && !cur_b && oor_q;
      b_err    <= (state == ACCESS) && cur_b && oor_q;

      if (grant_en) begin
        last_b         <= win_b;
        cur_b          <= win_b;
        we_q           <= sel_we;
        oor_q          <= !sel_in_range;
        DMEM_address   <= sel_in_range ? sel_addr : '0;
        DMEM_data_in   <= sel_wdata;
        DMEM_mem_write <= sel_in_range && sel_we;
        DMEM_mem_read  <= sel_in_range && !sel_we;
      end else begin
        // address/data hold; only the strobes drop outside ACCESS
        DMEM_mem_write <= 1'b0;
        DMEM_mem_read  <= 1'b0;
      end

      if ((state == ACCESS) && !we_q) begin
        if (cur_b) b_rdata <= oor_q ? '0 : DMEM_data_out;
        else       a_rdata <= oor_q ? '0 : DMEM_data_out;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating grant and conflict counters; stats_clr wins over increments
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_cnt        <= '0;
      b_cnt        <= '0;
      conflict_cnt <= '0;
    end else if (stats_clr) begin
      a_cnt        <= '0;
      b_cnt        <= '0;
      conflict_cnt <= '0;
    end else begin
      if (grant_en && !win_b && (a_cnt != 16'hFFFF)) a_cnt <= a_cnt + 16'd1;
      if (grant_en && win_b && (b_cnt != 16'hFFFF))  b_cnt <= b_cnt + 16'd1;
      if ((state == IDLE) && a_req && b_req && (conflict_cnt != 16'hFFFF))
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural DMEM
// (256x32, combinational read, write on posedge). Inputs change #1 after a
// posedge or on a negedge; outputs are sampled on negedges.
module tb_dmem_arbiter;

  logic        CLK;
  logic        RST_N;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;
  logic        dbg_state;
`ifdef DMEM_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] a_cnt, b_cnt, conflict_cnt;
`endif

  dmem_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
    .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
    .DMEM_data_out(DMEM_data_out),
`ifdef DMEM_ARB_STATS_EN
    .stats_clr(stats_clr), .a_cnt(a_cnt), .b_cnt(b_cnt), .conflict_cnt(conflict_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- DMEM model ----------------
  logic [31:0] mem [256];
  bit          mem_init_done = 1'b0;

  always @(posedge CLK) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_init_done <= 1'b1;
    end else if (DMEM_mem_write && (DMEM_address < 32'd256)) begin
      mem[DMEM_address[7:0]] <= DMEM_data_in;
    end
  end

  assign DMEM_data_out = (DMEM_address < 32'd256) ? mem[DMEM_address[7:0]] : 32'h0;

  // ---------------- protocol monitors ----------------
  bit both_gnt_seen    = 1'b0;
  bit both_strobe_seen = 1'b0;
  bit wr_in_rst_seen   = 1'b0;

  always @(posedge CLK) begin
    if (a_gnt && b_gnt)                  both_gnt_seen    <= 1'b1;
    if (DMEM_mem_write && DMEM_mem_read) both_strobe_seen <= 1'b1;
    if (!RST_N && DMEM_mem_write)        wr_in_rst_seen   <= 1'b1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  logic [31:0] obs_rdata, obs_daddr;
  logic        obs_err, obs_rvalid, obs_rd, obs_wr;

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // One complete access on a port; checks grant latency and captures results.
  task automatic access(input bit pb, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    int  n;
    bit  got;
    @(posedge CLK); #1;
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    n = 0; got = 1'b0;
    while (!got && n < 6) begin
      @(negedge CLK);
      n++;
      got = pb ? b_gnt : a_gnt;
    end
    check_val({tag, "_gnt_neg"}, 32'(n), 32'd2);
    check_val({tag, "_other_gnt"}, 32'(pb ? a_gnt : b_gnt), 32'd0);
    obs_rd    = DMEM_mem_read;
    obs_wr    = DMEM_mem_write;
    obs_daddr = DMEM_address;
    @(posedge CLK); #1;
    if (pb) b_req = 1'b0; else a_req = 1'b0;
    @(negedge CLK);
    obs_rvalid = pb ? b_rvalid : a_rvalid;
    obs_rdata  = pb ? b_rdata  : a_rdata;
    obs_err    = pb ? b_err    : a_err;
  endtask

  function automatic logic [31:0] mem_sum();
    logic [31:0] s = 32'h0;
    for (int i = 0; i < 256; i++) s = {s[30:0], s[31]} ^ mem[i] ^ 32'(i);
    return s;
  endfunction

  // ---------------- stimulus ----------------
  logic [3:0]  exp_flags [8];
  logic [31:0] sum_before;

  initial begin
    RST_N = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd3; a_wdata = 32'h1111_1111;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'd0; b_wdata = 32'h0;
`ifdef DMEM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset held with a pending A write: nothing may happen
    repeat (3) @(negedge CLK);
    check_val("rst_a_gnt",   32'(a_gnt), 32'd0);
    check_val("rst_wr",      32'(DMEM_mem_write), 32'd0);
    check_val("rst_a_rval",  32'(a_rvalid), 32'd0);
    check_val("rst_a_rdata", a_rdata, 32'h0);
    check_val("rst_daddr",   DMEM_address, 32'h0);
    check_val("rst_state",   32'(dbg_state), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("rel_a_gnt", 32'(a_gnt), 32'd1);
    check_val("rel_b_gnt", 32'(b_gnt), 32'd0);
    check_val("rel_wr",    32'(DMEM_mem_write), 32'd1);
    check_val("rel_daddr", DMEM_address, 32'd3);
    a_req = 1'b0;
    @(negedge CLK);
    check_val("rel_a_rval", 32'(a_rvalid), 32'd1);
    check_val("rel_a_gnt2", 32'(a_gnt), 32'd0);
    @(negedge CLK);
    check_val("rel_mem3", mem[3], 32'h1111_1111);

    // Port A write then read
    access(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, "wr5");
    check_val("wr5_strobe", 32'(obs_wr), 32'd1);
    check_val("wr5_daddr",  obs_daddr, 32'd5);
    check_val("wr5_rvalid", 32'(obs_rvalid), 32'd1);
    check_val("wr5_rdata_kept", obs_rdata, 32'h0);
    access(1'b0, 1'b0, 32'd5, 32'h0, "rd5");
    check_val("rd5_strobe", 32'(obs_rd), 32'd1);
    check_val("rd5_rvalid", 32'(obs_rvalid), 32'd1);
    check_val("rd5_rdata",  obs_rdata, 32'hDEAD_BEEF);
    check_val("rd5_err",    32'(obs_err), 32'd0);

    // Out-of-range read on B and write on A
    access(1'b1, 1'b0, 32'd3, 32'h0, "rd3b");
    check_val("rd3b_rdata", obs_rdata, 32'h1111_1111);
    access(1'b1, 1'b0, 32'd256, 32'h0, "oor_rd");
    check_val("oor_rd_strobe", 32'(obs_rd), 32'd0);
    check_val("oor_rd_daddr",  obs_daddr, 32'd0);
    check_val("oor_rd_rvalid", 32'(obs_rvalid), 32'd1);
    check_val("oor_rd_err",    32'(obs_err), 32'd1);
    check_val("oor_rd_rdata",  obs_rdata, 32'h0);
    sum_before = mem_sum();
    access(1'b0, 1'b1, 32'd300, 32'h5555_AAAA, "oor_wr");
    check_val("oor_wr_strobe", 32'(obs_wr), 32'd0);
    check_val("oor_wr_err",    32'(obs_err), 32'd1);
    @(negedge CLK);
    check_val("oor_wr_mem", mem_sum(), sum_before);
    check_val("oor_wr_rdata_kept", a_rdata, 32'hDEAD_BEEF);

    // Reset in the middle of a write access
    @(posedge CLK); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd7; a_wdata = 32'h1234_5678;
    repeat (2) @(negedge CLK);
    check_val("mid_gnt", 32'(a_gnt), 32'd1);
    RST_N = 1'b0;
    a_req = 1'b0;
    #1;
    check_val("mid_wr_async", 32'(DMEM_mem_write), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check_val("mid_rvalid", 32'(a_rvalid), 32'd0);
    end
    RST_N = 1'b1;
    @(negedge CLK);
    check_val("mid_rvalid_rel", 32'(a_rvalid), 32'd0);
    access(1'b0, 1'b0, 32'd7, 32'h0, "rd7");
    check_val("rd7_rdata", obs_rdata, 32'hA000_0007);

    // Continuous contention from reset: A, B, A, B
    do_reset();
    exp_flags = '{4'b1000, 4'b0010, 4'b0100, 4'b0001,
                  4'b1000, 4'b0010, 4'b0100, 4'b0001};
    @(posedge CLK); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd5;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd3;
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check_val($sformatf("cont_flags%0d", i),
                32'({a_gnt, b_gnt, a_rvalid, b_rvalid}), 32'(exp_flags[i]));
      if (a_rvalid) check_val($sformatf("cont_a_rdata%0d", i), a_rdata, 32'hDEAD_BEEF);
      if (b_rvalid) check_val($sformatf("cont_b_rdata%0d", i), b_rdata, 32'h1111_1111);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge CLK);
`ifdef DMEM_ARB_STATS_EN
    check_val("st_a_cnt",    32'(a_cnt), 32'd2);
    check_val("st_b_cnt",    32'(b_cnt), 32'd2);
    check_val("st_conflict", 32'(conflict_cnt), 32'd4);
    stats_clr = 1'b1;
    @(negedge CLK);
    stats_clr = 1'b0;
    check_val("st_clr_a",    32'(a_cnt), 32'd0);
    check_val("st_clr_b",    32'(b_cnt), 32'd0);
    check_val("st_clr_conf", 32'(conflict_cnt), 32'd0);
`endif

    // Global protocol properties
    check_val("never_both_gnt",    32'(both_gnt_seen), 32'd0);
    check_val("never_both_strobe", 32'(both_strobe_seen), 32'd0);
    check_val("no_write_in_reset", 32'(wr_in_rst_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
